div_sequencer: RTL
==================

// Module: div_sequencer
// PURPOSE
//  Multi-cycle unsigned 8-bit divider controller. It sequences one shared subEight
//  instance through an 8-step restoring division and returns quotient and remainder.
//  It sits beside the ALU as the CPU's DIV/MOD unit, using a start/busy/done handshake.
// PARAMETERS
//  DIV0_QUOT  8'hFF  quotient reported on divide-by-zero
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  start      in   1  request; sampled only when busy==0
//  dividend   in   8  captured on the accepted start edge
//  divisor    in   8  captured on the accepted start edge
//  busy       out  1  high in RUN and DONE states
//  done       out  1  one-cycle pulse, results valid
//  err        out  1  divide-by-zero flag, valid with done, held until next accept
//  quotient   out  8  held from done until the next accepted start
//  remainder  out  8  held from done until the next accepted start
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy=done=err=0; quotient=remainder=0;
//    step counter=0; internal registers cleared. Any division in progress is lost.
//  - States: IDLE -> RUN -> DONE -> IDLE. The DIV0 path is IDLE -> DONE.
//  - IDLE: start=1 at an edge, with divisor!=0:
//    - capture D=divisor, Q=dividend, R=0, cnt=0
//    - go to RUN
//  - IDLE: start=1 at an edge, with divisor==0:
//    - quotient=DIV0_QUOT, remainder=dividend, err=1
//    - go to DONE (done visible 1 cycle after the accept edge)
//  - RUN: each edge performs one step.
//    - t = {R[6:0], Q[7]}
//    - subEight computes t - D; b = borrow out of bit 7 (t < D)
//    - R <= b ? t : diff
//    - Q <= {Q[6:0], ~b}
//    - cnt++
//  - RUN exit: on the step with cnt==7, load quotient/remainder from the final values,
//    clear err, and go to DONE.
//  - Latency: exactly 8 RUN edges. done is high for the cycle after the 8th edge,
//    i.e. 9 cycles after the accept edge.
//  - DONE: done=1 for exactly one cycle, then IDLE. busy falls together with done.
//  - Widths: R[7] is provably 0 before each shift (R < D, and the dividend prefix is
//    below 2^7 at the last step), so t never exceeds 8 bits. No 9th remainder bit is kept.
//  - subEight enable=1 only in RUN, 0 otherwise. Its res output is gated to 0 when idle.
//    Its bOut must equal the bit-7 borrow (d0 < d1).
//  - start while busy (RUN or DONE) is ignored, with no queuing. Operand changes while
//    busy have no effect.
//  - start in IDLE on the same cycle DONE exits: there is no overlap. DONE->IDLE takes one
//    edge and the start is accepted on the next edge if still held.
//  - Outputs quotient, remainder and err hold stable from done until the next accepted
//    start. They then keep old values until the new done, except in the DIV0 path.
// STRUCTURE
//  - Shared header cpu_defs.vh:
//    - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
//    - DIV_STEPS=8
//  - Sub-module: one subEight instance (existing), d0=t, d1=D. No other sub-modules.
//  - FSM, counter and Q/R shift registers are local to div_sequencer.
// TESTING
//  - 200/7: done 9 cycles after accept -> quotient=28, remainder=4, err=0, busy low after.
//  - 255/1 -> 255,0.
//  - 5/9 -> 0,5.
//  - 255/255 -> 1,0.
//  - 0/3 -> 0,0.
//  - 0x9C/0 -> done 1 cycle after accept; quotient=0xFF, remainder=0x9C, err=1.
//    Next 10/3 -> 3,1 with err=0.
//  - 100/10 in progress; pulse start with 50/5 at RUN step 3 -> ignored; result 10,0.
//    done pulse is exactly 1 cycle wide.
//  - Assert rst at RUN step 4 of 200/7 -> outputs 0 immediately (async), state IDLE.
//    After release, 9/2 -> 4,1.
//  - Back-to-back: start held high continuously -> second division accepted on the edge
//    after DONE. Results change only at the second done.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg
//   Shared definitions for the DIV/MOD unit: FSM state encodings, step count
//   and a small helper for the step counter.
package div_sequencer_pkg;

  // FSM state encodings
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } divState_t;

  // one restoring step per dividend bit
  localparam int unsigned DIV_STEPS = 8;
  localparam logic [2:0]  LAST_STEP = 3'(DIV_STEPS - 1);

  // true on the step that produces the final quotient/remainder bits
  function automatic logic isLastStep(input logic [2:0] cnt);
    return (cnt == LAST_STEP);
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// div_sequencer_if
//   start/busy/done handshake bundle between a requester (master) and the
//   divider (slave).
//   start     requester -> divider   request, sampled only while busy==0
//   dividend  requester -> divider   8-bit operand, captured on accept
//   divisor   requester -> divider   8-bit operand, captured on accept
//   busy      divider -> requester   high in RUN and DONE
//   done      divider -> requester   one-cycle pulse, results valid
//   err       divider -> requester   divide-by-zero flag
//   quotient  divider -> requester   held from done until next accept
//   remainder divider -> requester   held from done until next accept
interface div_sequencer_if;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] quotient;
  logic [7:0] remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, err, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, err, quotient, remainder
  );
endinterface

// File: rtl/div_sequencer_sub_eight.sv
// subEight
//   Shared 8-bit subtractor used by the divider datapath.
//   d0, d1   8-bit operands, res = d0 - d1
//   enable   when low, res is forced to 0
//   res      8-bit difference (gated)
//   bOut     borrow out of bit 7, i.e. d0 < d1
module subEight (
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic       enable,
  output logic [7:0] res,
  output logic       bOut
);

  logic [8:0] wideDiff;

  // 9-bit subtract: bit 8 is the borrow out of bit 7
  always_comb begin
    wideDiff = {1'b0, d0} - {1'b0, d1};
    bOut     = wideDiff[8];
    if (enable) begin
      res = wideDiff[7:0];
    end else begin
      res = 8'h00;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer
//   Multi-cycle unsigned 8-bit restoring divider (CPU DIV/MOD unit). One
//   subEight instance is stepped 8 times per division.
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   bus       div_sequencer_if.slave: start/dividend/divisor in,
//             busy/done/err/quotient/remainder out (all registered)
//   DIV0_QUOT quotient reported on divide-by-zero (remainder = dividend)
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter logic [7:0] DIV0_QUOT = 8'hFF
) (
  input  logic            clk,
  input  logic            rst,
  div_sequencer_if.slave  bus
);

  divState_t  stateR;
  logic [7:0] dReg;
  logic [7:0] qReg;
  // R[7] is always 0 before a shift, so only 7 bits are carried between steps;
  // the full 8-bit final remainder is taken straight from nextRS.
  logic [6:0] rReg;
  logic [2:0] cntR;
  logic       busyR;
  logic       doneR;
  logic       errR;
  logic [7:0] quotR;
  logic [7:0] remR;

  logic [7:0] tS;
  logic [7:0] diffS;
  logic       borrowS;
  logic       enS;
  logic [7:0] nextRS;
  logic [7:0] nextQS;

  assign tS = {rReg, qReg[7]};
  assign enS = (stateR == ST_RUN);

  subEight uSub (
    .d0     (tS),
    .d1     (dReg),
    .enable (enS),
    .res    (diffS),
    .bOut   (borrowS)
  );

  // one restoring step: keep t on borrow, else take the difference
  always_comb begin
    if (borrowS) begin
      nextRS = tS;
    end else begin
      nextRS = diffS;
    end
    nextQS = {qReg[6:0], ~borrowS};
  end

  // sequencing FSM, step counter, shift registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateR <= ST_IDLE;
      dReg   <= 8'h00;
      qReg   <= 8'h00;
      rReg   <= 7'h00;
      cntR   <= 3'd0;
      busyR  <= 1'b0;
      doneR  <= 1'b0;
      errR   <= 1'b0;
      quotR  <= 8'h00;
      remR   <= 8'h00;
    end else begin
      case (stateR)
        ST_IDLE: begin
          doneR <= 1'b0;
          if (bus.start) begin
            busyR <= 1'b1;
            if (bus.divisor != 8'h00) begin
              dReg   <= bus.divisor;
              qReg   <= bus.dividend;
              rReg   <= 7'h00;
              cntR   <= 3'd0;
              stateR <= ST_RUN;
            end else begin
              // divide-by-zero skips RUN and reports immediately
              quotR  <= DIV0_QUOT;
              remR   <= bus.dividend;
              errR   <= 1'b1;
              doneR  <= 1'b1;
              stateR <= ST_DONE;
            end
          end else begin
            busyR <= 1'b0;
          end
        end
        ST_RUN: begin
          rReg <= nextRS[6:0];
          qReg <= nextQS;
          cntR <= cntR + 3'd1;
          if (isLastStep(cntR)) begin
            quotR  <= nextQS;
            remR   <= nextRS;
            errR   <= 1'b0;
            doneR  <= 1'b1;
            stateR <= ST_DONE;
          end else begin
            doneR <= 1'b0;
          end
        end
        ST_DONE: begin
          // busy and done fall together; a held start is seen next edge
          doneR  <= 1'b0;
          busyR  <= 1'b0;
          stateR <= ST_IDLE;
        end
        default: begin
          doneR  <= 1'b0;
          busyR  <= 1'b0;
          stateR <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busyR;
  assign bus.done      = doneR;
  assign bus.err       = errR;
  assign bus.quotient  = quotR;
  assign bus.remainder = remR;

endmodule
